// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues single-outstanding reads to a
// synchronous instruction memory and buffers returned words in a small in-order
// queue that feeds decode over a valid/ready handshake. A redirect flushes all
// wrong-path state and reloads the PC.
module instr_fetch_queue #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 11,
    parameter int Q_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_oen,
    input  logic [DATA_W-1:0] im_dataout,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // one extra bit so count + inflight never wraps in the room check
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(Q_DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic              inflight;

    logic [DATA_W-1:0] q_instr [Q_DEPTH];
    logic [ADDR_W-1:0] q_pc    [Q_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              pop;
    logic              capture;
    logic              issue;
    logic [CNT_W:0]    occ;

    assign if_valid = (count != '0);
    assign pop      = if_valid & if_ready;
    // a word returning while a redirect is taken is on the wrong path
    assign capture  = inflight & ~redirect_valid;
    // slots that will be held after this cycle's pop, counting the outstanding read,
    // so every issued read is guaranteed a free entry when it returns
    assign occ      = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign issue    = ~rst & en & ~redirect_valid & (occ < DEPTH_V);

    assign im_addr  = pc;
    assign im_oen   = ~issue;
    assign if_instr = if_valid ? q_instr[rd_ptr] : '0;
    assign if_pc    = if_valid ? q_pc[rd_ptr]    : '0;

    // PC, outstanding-read flag and the PC tag of the outstanding read
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            tag      <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag <= pc;
                pc  <= pc + ADDR_W'(1);
            end
        end
    end

    // queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (capture) wr_ptr <= wr_ptr + PTR_W'(1);
            case ({capture, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // queue storage: returned word written with the PC it was fetched from
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (capture) begin
            q_instr[wr_ptr] <= im_dataout;
            q_pc[wr_ptr]    <= tag;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a synchronous memory model returning
// 0x100+addr, a decode-side model of the expected PC stream, and hand-computed
// cycle-exact checks for latency, backpressure, redirect, wrap, en=0 and reset.
module tb_instr_fetch_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] im_addr;
    logic              im_oen;
    logic [DATA_W-1:0] im_dataout;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Q_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .im_addr(im_addr), .im_oen(im_oen), .im_dataout(im_dataout),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    // synchronous memory: mem[a] = 0x100 + a, garbage when not read
    always @(posedge clk) begin
        if (!im_oen) im_dataout <= 32'h100 + {21'd0, im_addr};
        else         im_dataout <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // decode-side model: the next PC decode must see, in program order
    logic [ADDR_W-1:0] exp_pc = '0;
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = '0;
        end else begin
            if (if_valid) begin
                check("model_pc", 32'(if_pc), 32'(exp_pc));
                check("model_instr", if_instr, 32'h100 + 32'(if_pc));
            end
            if (redirect_valid)             exp_pc = redirect_pc;
            else if (if_valid && if_ready)  exp_pc = exp_pc + 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [ADDR_W-1:0] h;

    initial begin
        rst = 1'b1; en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        rst = 1'b0;
        // reset state
        @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 0);
        check("rst_im_oen",   32'(im_oen),   1);
        check("rst_im_addr",  32'(im_addr),  0);
        check("rst_if_pc",    32'(if_pc),    0);
        check("rst_if_instr", if_instr,      0);

        // 1: first issue in N, valid in N+2, one per cycle
        tick(); en = 1'b1; if_ready = 1'b1;
        @(negedge clk);
        check("t1_oen_N",  32'(im_oen),  0);
        check("t1_addr_N", 32'(im_addr), 0);
        tick(); @(negedge clk);
        check("t1_valid_N1", 32'(if_valid), 0);
        check("t1_addr_N1",  32'(im_addr),  1);
        tick(); @(negedge clk);
        check("t1_valid_N2", 32'(if_valid), 1);
        check("t1_pc_N2",    32'(if_pc),    0);
        check("t1_instr_N2", if_instr,      32'h100);
        for (int i = 1; i <= 8; i++) begin
            tick(); @(negedge clk);
            check("t1_stream_valid", 32'(if_valid), 1);
            check("t1_stream_pc",    32'(if_pc),    i);
        end

        // 2: backpressure for 5 cycles
        tick(); if_ready = 1'b0;
        @(negedge clk);
        h = if_pc;
        check("t2_pc_B0", 32'(h), 9);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin tick(); @(negedge clk); end
            check("t2_held_pc", 32'(if_pc),  32'(h));
            check("t2_oen",     32'(im_oen), 1);
        end
        check("t2_count_full", 32'(dut.count), 2);
        tick(); if_ready = 1'b1;
        @(negedge clk);
        check("t2_rel_pc0", 32'(if_pc), 32'(h));
        tick(); @(negedge clk);
        check("t2_rel_pc1", 32'(if_pc), 32'(h) + 1);
        for (int i = 0; i < 4; i++) begin tick(); @(negedge clk); end

        // 3: redirect to 0x40 with a read outstanding
        tick(); redirect_valid = 1'b1; redirect_pc = 11'h040;
        @(negedge clk);
        check("t3_oen_R", 32'(im_oen), 1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_valid_R1", 32'(if_valid), 0);
        check("t3_addr_R1",  32'(im_addr),  32'h40);
        check("t3_oen_R1",   32'(im_oen),   0);
        tick(); @(negedge clk);
        check("t3_valid_R2", 32'(if_valid), 0);
        tick(); @(negedge clk);
        check("t3_valid_R3", 32'(if_valid), 1);
        check("t3_pc_R3",    32'(if_pc),    32'h40);
        check("t3_instr_R3", if_instr,      32'h140);
        for (int i = 0; i < 3; i++) begin tick(); @(negedge clk); end

        // 4: redirect near the top of the address space, PC wraps
        tick(); redirect_valid = 1'b1; redirect_pc = 11'h7FE;
        tick(); redirect_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        check("t4_pc0", 32'(if_pc), 32'h7FE);
        check("t4_instr0", if_instr, 32'h8FE);
        tick(); @(negedge clk);
        check("t4_pc1", 32'(if_pc), 32'h7FF);
        tick(); @(negedge clk);
        check("t4_pc2", 32'(if_pc), 32'h000);
        check("t4_instr2", if_instr, 32'h100);
        tick(); @(negedge clk);
        check("t4_pc3", 32'(if_pc), 32'h001);
        for (int i = 0; i < 3; i++) begin tick(); @(negedge clk); end

        // 5: fill two entries, then drain with en=0
        tick(); if_ready = 1'b0;
        tick();
        tick(); en = 1'b0; if_ready = 1'b1;
        @(negedge clk);
        h = if_pc;
        check("t5_valid_D0", 32'(if_valid), 1);
        check("t5_oen_D0",   32'(im_oen),   1);
        tick(); @(negedge clk);
        check("t5_valid_D1", 32'(if_valid), 1);
        check("t5_pc_D1",    32'(if_pc),    32'(h) + 1);
        check("t5_oen_D1",   32'(im_oen),   1);
        tick(); @(negedge clk);
        check("t5_valid_D2", 32'(if_valid), 0);
        check("t5_oen_D2",   32'(im_oen),   1);
        tick(); @(negedge clk);
        check("t5_valid_D3", 32'(if_valid), 0);
        tick(); en = 1'b1;
        @(negedge clk);
        check("t5_resume_oen",  32'(im_oen),  0);
        check("t5_resume_addr", 32'(im_addr), 32'(h) + 2);
        tick(); tick(); @(negedge clk);
        check("t5_resume_pc", 32'(if_pc), 32'(h) + 2);
        for (int i = 0; i < 3; i++) begin tick(); @(negedge clk); end

        // 6: reset mid-stream with a read outstanding
        check("t6_inflight_pre", 32'(im_oen), 0);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        check("t6_valid_X1", 32'(if_valid), 0);
        check("t6_addr_X1",  32'(im_addr),  0);
        check("t6_pc_X1",    32'(if_pc),    0);
        tick(); @(negedge clk);
        check("t6_valid_X2", 32'(if_valid), 0);
        tick(); @(negedge clk);
        check("t6_valid_X3", 32'(if_valid), 1);
        check("t6_pc_X3",    32'(if_pc),    0);
        check("t6_instr_X3", if_instr,      32'h100);
        for (int i = 0; i < 4; i++) begin tick(); @(negedge clk); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
